// File: rtl/turn_sequencer.sv
// turn_sequencer: turn-based board-game sequencer for two players.
// A rising edge on i_roll_req rolls a die (free-running 0..5 counter + 1, or
// i_forced_dice when it is 1..6). The roll advances the active player's tile,
// clamped at the flag tile. The sequencer then publishes the new target x
// coordinates with a single-cycle o_pos_valid pulse and waits for i_turn_done.
// After that it either declares a winner or hands the turn to the other player.
// Optional build macro: EXTRA_TURN_ON_SIX_EN. When it is defined, a roll of 6
// that does not win keeps the same player active for another roll.
module turn_sequencer #(
   parameter int START_X   = 20,
   parameter int TILE_W    = 40,
   parameter int LAST_TILE = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_roll_req,
   input  logic [2:0] i_forced_dice,
   input  logic       i_turn_done,
   output logic [9:0] o_player1_pos_x,
   output logic [9:0] o_player2_pos_x,
   output logic       o_pos_valid,
   output logic       o_active_player,
   output logic [2:0] o_dice_value,
   output logic       o_busy,
   output logic       o_game_over,
   output logic       o_winner
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ROLL      = 3'd1,
      S_CALC      = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_NEXT      = 3'd5,
      S_GAME_OVER = 3'd6
   } state_t;

   localparam logic [4:0] LP_LAST_TILE = 5'(LAST_TILE);
   localparam logic [9:0] LP_START_X   = 10'(START_X);
   localparam logic [9:0] LP_TILE_W    = 10'(TILE_W);

   // Pixel x coordinate of a tile index
   function automatic logic [9:0] tile_to_x(input logic [4:0] tile);
      tile_to_x = LP_START_X + (10'(tile) * LP_TILE_W);
   endfunction

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_die_cnt;
   logic       r_roll_d;
   logic [4:0] r_tile1;
   logic [4:0] r_tile2;
   logic [9:0] r_pos1;
   logic [9:0] r_pos2;
   logic       r_pos_valid;
   logic       r_active;
   logic [2:0] r_dice;
   logic       r_busy;
   logic       r_game_over;
   logic       r_winner;

   logic       w_edge;
   logic       w_forced_ok;
   logic [2:0] w_roll_val;
   logic [4:0] w_cur_tile;
   logic [4:0] w_sum;
   logic [4:0] w_new_tile;
   logic       w_pos_valid_nxt;
   logic       w_busy_nxt;

   assign w_edge      = i_roll_req & ~r_roll_d;
   assign w_forced_ok = (i_forced_dice != 3'd0) && (i_forced_dice != 3'd7);
   assign w_roll_val  = r_die_cnt + 3'd1;

   // Current tile of the active player and its clamped advance
   always_comb begin
      w_cur_tile = 5'd0;
      if (r_active) begin
         w_cur_tile = r_tile2;
      end else begin
         w_cur_tile = r_tile1;
      end
      w_sum = w_cur_tile + {2'b00, r_dice};
      if (w_sum > LP_LAST_TILE) begin
         w_new_tile = LP_LAST_TILE;
      end else begin
         w_new_tile = w_sum;
      end
   end

   // Free-running die counter 0..5 and roll_req history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_die_cnt <= 3'd0;
         r_roll_d  <= 1'b0;
      end else begin
         r_roll_d <= i_roll_req;
         if (r_die_cnt == 3'd5) begin
            r_die_cnt <= 3'd0;
         end else begin
            r_die_cnt <= r_die_cnt + 3'd1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; edges outside IDLE are dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_edge) begin
               w_state_nxt = S_ROLL;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ROLL:  w_state_nxt = S_CALC;
         S_CALC:  w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (i_turn_done) begin
               w_state_nxt = S_NEXT;
            end else begin
               w_state_nxt = S_WAIT_DONE;
            end
         end
         S_NEXT: begin
            if (w_cur_tile == LP_LAST_TILE) begin
               w_state_nxt = S_GAME_OVER;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GAME_OVER: w_state_nxt = S_GAME_OVER;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // FSM output decode, computed from the next state so outputs can be registered
   always_comb begin
      w_pos_valid_nxt = 1'b0;
      w_busy_nxt      = 1'b0;
      case (w_state_nxt)
         S_IDLE:      w_busy_nxt = 1'b0;
         S_ROLL:      w_busy_nxt = 1'b1;
         S_CALC:      w_busy_nxt = 1'b1;
         S_ISSUE: begin
            w_busy_nxt      = 1'b1;
            w_pos_valid_nxt = 1'b1;
         end
         S_WAIT_DONE: w_busy_nxt = 1'b1;
         S_NEXT:      w_busy_nxt = 1'b1;
         S_GAME_OVER: w_busy_nxt = 1'b0;
         default:     w_busy_nxt = 1'b0;
      endcase
   end

   // Registered FSM status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_pos_valid <= w_pos_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Game datapath: die latch, tile/position update, turn hand-over, win flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dice      <= 3'd0;
         r_tile1     <= 5'd0;
         r_tile2     <= 5'd0;
         r_pos1      <= LP_START_X;
         r_pos2      <= LP_START_X;
         r_active    <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
      end else begin
         case (r_state)
            S_ROLL: begin
               if (w_forced_ok) begin
                  r_dice <= i_forced_dice;
               end else begin
                  r_dice <= w_roll_val;
               end
            end
            S_CALC: begin
               if (r_active) begin
                  r_tile2 <= w_new_tile;
                  r_pos2  <= tile_to_x(w_new_tile);
               end else begin
                  r_tile1 <= w_new_tile;
                  r_pos1  <= tile_to_x(w_new_tile);
               end
            end
            S_NEXT: begin
               if (w_cur_tile == LP_LAST_TILE) begin
                  r_game_over <= 1'b1;
                  r_winner    <= r_active;
               end
`ifdef EXTRA_TURN_ON_SIX_EN
               else if (r_dice == 3'd6) begin
                  r_active <= r_active;
               end
`endif
               else begin
                  r_active <= ~r_active;
               end
            end
            default: begin
               r_dice <= r_dice;
            end
         endcase
      end
   end

   assign o_player1_pos_x = r_pos1;
   assign o_player2_pos_x = r_pos2;
   assign o_pos_valid     = r_pos_valid;
   assign o_active_player = r_active;
   assign o_dice_value    = r_dice;
   assign o_busy          = r_busy;
   assign o_game_over     = r_game_over;
   assign o_winner        = r_winner;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: a table of forced-die turns that
// plays a full game, plus directed sequences for the multi-cycle corner cases.
module tb_turn_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       roll_req = 1'b0;
   logic [2:0] forced = 3'd0;
   logic       turn_done = 1'b0;
   logic [9:0] p1_x;
   logic [9:0] p2_x;
   logic       pos_valid;
   logic       active;
   logic [2:0] dice;
   logic       busy;
   logic       game_over;
   logic       winner;

   int n_total = 0;
   int n_pass  = 0;

   turn_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .i_roll_req      (roll_req),
      .i_forced_dice   (forced),
      .i_turn_done     (turn_done),
      .o_player1_pos_x (p1_x),
      .o_player2_pos_x (p2_x),
      .o_pos_valid     (pos_valid),
      .o_active_player (active),
      .o_dice_value    (dice),
      .o_busy          (busy),
      .o_game_over     (game_over),
      .o_winner        (winner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] forced;
      int exp_dice;
      int exp_p1;
      int exp_p2;
      int exp_active;
      int exp_over;
      int exp_winner;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Start a turn and follow it into WAIT_DONE
   task automatic do_turn(input logic [2:0] f, input bit extra_edge, input bit done_in_issue);
      int  n;
      bit  seen;
      bit  pv_again;
      @(negedge clk);
      forced   = f;
      roll_req = 1'b1;
      n = 0;
      seen = 1'b0;
      while (n < 10 && !seen) begin
         @(negedge clk);
         n++;
         seen = pos_valid;
      end
      chk("pos_valid_latency", seen ? n : 99, 3);
      if (done_in_issue) turn_done = 1'b1;
      roll_req = 1'b0;
      @(negedge clk);
      turn_done = 1'b0;
      chk("pos_valid_one_cycle", int'(pos_valid), 0);
      chk("busy_in_turn", int'(busy), 1);
      if (extra_edge) begin
         roll_req = 1'b1;
         @(negedge clk);
         @(negedge clk);
         roll_req = 1'b0;
      end
      pv_again = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (pos_valid) pv_again = 1'b1;
      end
      chk("no_extra_pos_valid", int'(pv_again), 0);
      chk("wait_done_holds", int'(busy), 1);
   endtask

   // Pulse turn_done and let NEXT complete
   task automatic end_turn();
      @(negedge clk);
      turn_done = 1'b1;
      @(negedge clk);
      turn_done = 1'b0;
      @(negedge clk);
   endtask

   initial begin : main
      int m_tile[2];
      int m_active;
      int m_over;
      int nt;
      int exp_act6;
      bit pv;

      vecs[0] = '{3'd3, 3, 140,  20, 1, 0, 0};
      vecs[1] = '{3'd5, 5, 140, 220, 0, 0, 0};
      vecs[2] = '{3'd5, 5, 340, 220, 1, 0, 0};
      vecs[3] = '{3'd1, 1, 340, 260, 0, 0, 0};
      vecs[4] = '{3'd5, 5, 540, 260, 1, 0, 0};
      vecs[5] = '{3'd2, 2, 540, 340, 0, 0, 0};
      vecs[6] = '{3'd6, 6, 620, 340, 0, 1, 0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_p1_x", int'(p1_x), 20);
      chk("rst_p2_x", int'(p2_x), 20);
      chk("rst_pos_valid", int'(pos_valid), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_dice", int'(dice), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_game_over", int'(game_over), 0);
      chk("rst_winner", int'(winner), 0);

      // Full game from the table
      for (int i = 0; i < 7; i++) begin
         if (i == 3) begin
            // turn_done in IDLE must do nothing
            turn_done = 1'b1;
            @(negedge clk);
            turn_done = 1'b0;
            pv = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (pos_valid || busy) pv = 1'b1;
            end
            chk("idle_turn_done_ignored", int'(pv), 0);
            chk("idle_active_kept", int'(active), 1);
         end
         do_turn(vecs[i].forced, i == 1, i == 2);
         chk("vec_dice", int'(dice), vecs[i].exp_dice);
         chk("vec_p1_x", int'(p1_x), vecs[i].exp_p1);
         chk("vec_p2_x", int'(p2_x), vecs[i].exp_p2);
         end_turn();
         chk("vec_active", int'(active), vecs[i].exp_active);
         chk("vec_busy_after", int'(busy), 0);
         chk("vec_game_over", int'(game_over), vecs[i].exp_over);
         chk("vec_winner", int'(winner), vecs[i].exp_winner);
      end

      // Roll edges after the win are ignored and outputs stay frozen
      roll_req = 1'b1;
      @(negedge clk);
      roll_req = 1'b0;
      @(negedge clk);
      roll_req = 1'b1;
      pv = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (pos_valid || busy) pv = 1'b1;
      end
      roll_req = 1'b0;
      chk("over_edges_ignored", int'(pv), 0);
      chk("over_p1_frozen", int'(p1_x), 620);
      chk("over_flag_sticky", int'(game_over), 1);
      chk("over_active_frozen", int'(active), 0);

      // Asynchronous reset while waiting for turn_done
      pulse_rst();
      do_turn(3'd4, 1'b0, 1'b0);
      chk("pre_rst_p1_x", int'(p1_x), 180);
      rst = 1'b1;
      #1;
      chk("midrst_p1_x", int'(p1_x), 20);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_dice", int'(dice), 0);
      chk("midrst_pos_valid", int'(pos_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      do_turn(3'd2, 1'b0, 1'b0);
      chk("postrst_p1_x", int'(p1_x), 100);
      chk("postrst_p2_x", int'(p2_x), 20);
      end_turn();
      chk("postrst_active", int'(active), 1);

      // Six from tile 0: extra turn only when the macro is defined
`ifdef EXTRA_TURN_ON_SIX_EN
      exp_act6 = 0;
`else
      exp_act6 = 1;
`endif
      pulse_rst();
      do_turn(3'd6, 1'b0, 1'b0);
      chk("six_p1_x", int'(p1_x), 260);
      end_turn();
      chk("six_active", int'(active), exp_act6);

      // Internal die across 100 rolls, with a small board model
      pulse_rst();
      m_tile[0] = 0;
      m_tile[1] = 0;
      m_active  = 0;
      m_over    = 0;
      for (int i = 0; i < 100; i++) begin
         if (m_over != 0) begin
            pulse_rst();
            m_tile[0] = 0;
            m_tile[1] = 0;
            m_active  = 0;
            m_over    = 0;
         end
         do_turn((i % 2) ? 3'd7 : 3'd0, 1'b0, 1'b0);
         chk("rand_dice_range", int'(dice >= 3'd1 && dice <= 3'd6), 1);
         nt = m_tile[m_active] + int'(dice);
         if (nt > 15) nt = 15;
         m_tile[m_active] = nt;
         chk("rand_pos_x", m_active ? int'(p2_x) : int'(p1_x), 20 + 40 * nt);
         end_turn();
         if (nt == 15) begin
            m_over = 1;
         end else begin
`ifdef EXTRA_TURN_ON_SIX_EN
            if (dice != 3'd6) m_active = 1 - m_active;
`else
            m_active = 1 - m_active;
`endif
         end
         chk("rand_game_over", int'(game_over), m_over);
         chk("rand_active", int'(active), m_active);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
